// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, fetches words over req/gnt + rvalid, buffers {pc, inst} for decode.
// Latency: redirect at N -> imem_req at N+1 -> inst_valid_o at N+3 with a 1-cycle memory.
// Backpressure: decode stalls fill the buffer; no request is issued unless a free slot is guaranteed.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [31:0] RESET_PC_AL  = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic               drop_q, drop_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [BUF_DEPTH];
    entry_t             mem_d [BUF_DEPTH];
    entry_t             head;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Head of the buffer drives decode; outputs read as zero while empty.
    assign head         = mem_q[rd_ptr_q];
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? head.inst : '0;
    assign inst_pc_o    = inst_valid_o ? head.pc   : '0;
    assign imem_addr    = pc_q;

    // Buffer update: a redirect flushes everything and overrides any push or pop this cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop      = inst_valid_o & inst_ready_i;
        push     = (state_q == WAIT) & imem_rvalid & ~drop_q & ~redirect_i;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: req_pc_q, inst: imem_rdata};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch FSM: request only with a guaranteed free slot; a redirect retargets the PC and
    // marks any in-flight response for discard.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q < DEPTH_C || redirect_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                    if (redirect_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // The outstanding response is consumed now, so nothing is left to drop.
                    drop_d  = 1'b0;
                    state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_i) begin
            pc_d = redirect_pc_i & 32'hFFFF_FFFC;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC_AL;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
// Directed bench for inst_fetch: memory responder, delivery log, hand-computed expectations.
// Latency: checks taken 1ns after rising edges; memory acts on falling edges.
// Backpressure: decode ready is driven per scenario to exercise stall and resume.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          ovf_cnt = 0;

    // memory model controls
    bit          gnt_en;
    int          lat;
    bit          ovr;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;

    logic [31:0] flog[$];
    logic [31:0] dpc[$];
    logic [31:0] ddat[$];

    inst_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flog_at(input int k);
        return (k < flog.size()) ? flog[k] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] dpc_at(input int k);
        return (k < dpc.size()) ? dpc[k] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] ddat_at(input int k);
        return (k < ddat.size()) ? ddat[k] : 32'hBAD0_BAD0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns on the falling edge where reset is released; queues start empty.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        redirect_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flog.delete();
        dpc.delete();
        ddat.delete();
        rst = 1'b1;
    endtask

    // Memory responder (one outstanding fetch), delivery log and overflow watch.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_data   = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_data;
                    pend        = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (gnt_en && imem_req && !pend && !imem_rvalid) begin
                imem_gnt  = 1'b1;
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_data = ovr ? 32'hDEAD_BEEF : ~imem_addr;
                ovr       = 1'b0;
                flog.push_back(imem_addr);
            end
            if (inst_valid_o && inst_ready_i && !redirect_i) begin
                dpc.push_back(inst_pc_o);
                ddat.push_back(inst_o);
            end
            if (dut.push && !dut.pop && dut.count_q == dut.DEPTH_C) begin
                ovf_cnt++;
            end
        end
    end

    initial begin
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        inst_ready_i  = 1'b1;
        gnt_en        = 1'b1;
        lat           = 1;
        ovr           = 1'b0;

        // reset values
        #3;
        chk("rst_req",   {31'd0, imem_req},     32'd0);
        chk("rst_addr",  imem_addr,             32'h0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst",  inst_o,                32'h0);
        chk("rst_pc",    inst_pc_o,             32'h0);

        // in-order fetch, first valid 3 cycles after release
        do_reset();
        tick();
        chk("t1_req_c1",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr_c1", imem_addr,         32'h0);
        tick();
        chk("t1_valid_c2", {31'd0, inst_valid_o}, 32'd0);
        tick();
        chk("t1_valid_c3", {31'd0, inst_valid_o}, 32'd1);
        chk("t1_pc_c3",    inst_pc_o,             32'h0);
        chk("t1_inst_c3",  inst_o,                32'hFFFF_FFFF);
        repeat (8) tick();
        chk("t1_fetch0", flog_at(0), 32'h0);
        chk("t1_fetch1", flog_at(1), 32'h4);
        chk("t1_fetch2", flog_at(2), 32'h8);
        chk("t1_dpc1",   dpc_at(1),  32'h4);
        chk("t1_dpc2",   dpc_at(2),  32'h8);
        chk("t1_ddat2",  ddat_at(2), 32'hFFFF_FFF7);

        // decode stall fills the buffer, then resume
        inst_ready_i = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("t2_nfetch", 32'(flog.size()),      32'd2);
        chk("t2_req",    {31'd0, imem_req},     32'd0);
        chk("t2_valid",  {31'd0, inst_valid_o}, 32'd1);
        chk("t2_pc",     inst_pc_o,             32'h0);
        chk("t2_inst",   inst_o,                32'hFFFF_FFFF);
        inst_ready_i = 1'b1;
        repeat (14) tick();
        chk("t2_fetch2", flog_at(2), 32'h8);
        chk("t2_dpc0",   dpc_at(0),  32'h0);
        chk("t2_dpc1",   dpc_at(1),  32'h4);
        chk("t2_dpc2",   dpc_at(2),  32'h8);
        chk("t2_dpc3",   dpc_at(3),  32'hC);
        chk("t2_ddat3",  ddat_at(3), 32'hFFFF_FFF3);

        // redirect while waiting on a late response
        lat = 3;
        ovr = 1'b1;
        do_reset();
        tick();
        tick();
        chk("t3_wait_req", {31'd0, imem_req}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1002;
        tick();
        redirect_i = 1'b0;
        lat        = 1;
        chk("t3_addr_redir", imem_addr,             32'h0000_1000);
        chk("t3_valid",      {31'd0, inst_valid_o}, 32'd0);
        repeat (8) tick();
        chk("t3_fetch1", flog_at(1), 32'h0000_1000);
        chk("t3_dpc0",   dpc_at(0),  32'h0000_1000);
        chk("t3_ddat0",  ddat_at(0), 32'hFFFF_EFFF);

        // redirect coinciding with a grant and a pop
        do_reset();
        repeat (3) tick();
        chk("t4_valid_pre", {31'd0, inst_valid_o}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        chk("t4_valid_flush", {31'd0, inst_valid_o}, 32'd0);
        chk("t4_req",         {31'd0, imem_req},     32'd0);
        chk("t4_addr",        imem_addr,             32'h0000_0200);
        repeat (8) tick();
        chk("t4_fetch1", flog_at(1), 32'h4);
        chk("t4_fetch2", flog_at(2), 32'h0000_0200);
        chk("t4_dpc0",   dpc_at(0),  32'h0000_0200);
        chk("t4_ddat0",  ddat_at(0), 32'hFFFF_FDFF);

        // PC wrap at the top of the address space, redirect taken from IDLE
        do_reset();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        chk("t5_req",  {31'd0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr,         32'hFFFF_FFFC);
        tick();
        tick();
        chk("t5_valid",     {31'd0, inst_valid_o}, 32'd1);
        chk("t5_pc",        inst_pc_o,             32'hFFFF_FFFC);
        chk("t5_inst",      inst_o,                32'h0000_0003);
        chk("t5_wrap_req",  {31'd0, imem_req},     32'd1);
        chk("t5_wrap_addr", imem_addr,             32'h0000_0000);

        // asynchronous reset mid-WAIT with one buffered entry; stale response must vanish
        inst_ready_i = 1'b0;
        lat          = 1;
        do_reset();
        repeat (3) tick();
        lat = 3;
        ovr = 1'b1;
        chk("t6_valid_pre", {31'd0, inst_valid_o}, 32'd1);
        tick();
        chk("t6_wait_req", {31'd0, imem_req}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_arst_req",   {31'd0, imem_req},     32'd0);
        chk("t6_arst_addr",  imem_addr,             32'h0);
        chk("t6_arst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("t6_arst_inst",  inst_o,                32'h0);
        chk("t6_arst_pc",    inst_pc_o,             32'h0);
        @(posedge clk);
        @(negedge clk);
        flog.delete();
        dpc.delete();
        ddat.delete();
        lat          = 1;
        inst_ready_i = 1'b1;
        rst          = 1'b1;
        tick();
        chk("t6_restart_req",  {31'd0, imem_req}, 32'd1);
        chk("t6_restart_addr", imem_addr,         32'h0);
        tick();
        chk("t6_stale_valid", {31'd0, inst_valid_o}, 32'd0);
        repeat (10) tick();
        chk("t6_fetch0", flog_at(0), 32'h0);
        chk("t6_dpc0",   dpc_at(0),  32'h0);
        chk("t6_ddat0",  ddat_at(0), 32'hFFFF_FFFF);
        chk("t6_dpc1",   dpc_at(1),  32'h4);
        chk("t6_ddat1",  ddat_at(1), 32'hFFFF_FFFB);

        // ungranted request holds its address until a redirect retargets it
        gnt_en = 1'b0;
        do_reset();
        tick();
        chk("t7_req",  {31'd0, imem_req}, 32'd1);
        repeat (3) tick();
        chk("t7_hold_addr", imem_addr,         32'h0);
        chk("t7_hold_req",  {31'd0, imem_req}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        tick();
        redirect_i = 1'b0;
        chk("t7_retarget_addr", imem_addr,         32'h0000_0040);
        chk("t7_retarget_req",  {31'd0, imem_req}, 32'd1);
        gnt_en = 1'b1;
        repeat (6) tick();
        chk("t7_fetch0", flog_at(0), 32'h0000_0040);
        chk("t7_dpc0",   dpc_at(0),  32'h0000_0040);

        chk("no_overflow", 32'(ovf_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
